seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the combinational execute-stage ALU. Adds SUB, arithmetic shift, set-less-than and iterative multiply/divide ops; produces a registered result with {N,V,Z} status. Sits between the decode/register-read stage and writeback, and stalls the front end through valid/ready while a multi-cycle op runs.

## Interface
- WIDTH, 32: operand and result width; must be at least 8 and a power of 2.
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from b[SHAMT_W-1:0].
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  alu_op_t operation code.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result and status are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- status  out  3  {NEGATIVE, OVERFLOW, ZERO}, registered with result.
- busy  out  1  a multi-cycle op is in progress.

## Operation
- Accept when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE.
  - BUSY: multi-cycle op iterating.
  - DONE: result held until out_ready.
- Transitions:
  - IDLE or DONE-with-handshake, on accept of a single-cycle op: to DONE.
  - IDLE or DONE-with-handshake, on accept of a multi-cycle op: to BUSY.
  - DONE with out_ready and no accept: to IDLE.
  - BUSY, after the final iteration: to DONE.
- Op codes: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Codes 0-9 are single-cycle; codes 10-15 are multi-cycle.
- SLT/SLTU: result = {WIDTH-1 zeros, lt}, using signed/unsigned compare respectively.
- Shifts use b[SHAMT_W-1:0] only. SRA sign-fills from a[WIDTH-1].
- MUL: low WIDTH bits of the unsigned product. MULHU: high WIDTH bits of the 2*WIDTH-bit unsigned product.
- DIV/REM: signed, quotient truncated toward zero; the remainder takes the dividend's sign.
- Divide by zero (b==0): quotient = all ones; REM/REMU result = a.
- Signed overflow (a = most-negative value, b = -1): DIV returns a; REM returns 0.
- Status:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V = signed two's-complement overflow for ADD/SUB; 0 for every other op.
- Operands are captured at accept; a and b may change afterwards without effect.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, status=3'b000, state=IDLE, iteration counter=0.
- Single-cycle op accepted in cycle T: out_valid=1 in cycle T+1.
- Multi-cycle op accepted in cycle T:
  - busy=1 in cycles T+1..T+WIDTH.
  - out_valid=1 in cycle T+WIDTH+1.
  - A radix-2 shift-add or restoring-divide step runs each cycle; the counter runs WIDTH-1 down to 0.
- Divide by zero and the signed-overflow case bypass BUSY: out_valid=1 in cycle T+1.
- Throughput: back-to-back single-cycle ops run at one per cycle while out_ready=1.
- During BUSY: in_ready=0 and out_valid=0.
- result/status hold stable while out_valid && !out_ready.
- Result handed off and a new op accepted in the same cycle: out_valid stays 1 and the new result appears next cycle.
- Reset asserted mid-BUSY or in DONE: the in-flight op is discarded and outputs return to reset values immediately.

## Structure
- Package alu_pkg:
  - alu_op_t: 4-bit enum with the codes above.
  - is_multicycle(op) function.
  - Status bit indices STAT_Z=0, STAT_V=1, STAT_N=2.
  - state_t enum {IDLE, BUSY, DONE}.
- Sub-module mul_div_iter (WIDTH):
  - Inputs: start, op, a, b.
  - Outputs: done, res.
  - Holds the sign-magnitude conversion, the iteration registers and the counter.
- The top level holds the single-cycle datapath, the FSM, and the output/status registers.

## Test plan
All scenarios use WIDTH=32.
- ADD a=32'h7FFF_FFFF, b=1 -> result 32'h8000_0000, status 3'b110, out_valid one cycle after accept.
- SUB a=5, b=5 -> result 0, status 3'b001. SRA a=32'h8000_0000, b=32'h0000_0024 (shamt 4) -> 32'hF800_0000.
- MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE, out_valid exactly 33 cycles after accept, busy high for 32 cycles, in_ready low throughout.
- DIV a=-7, b=2 -> 32'hFFFF_FFFD; REM gives 32'hFFFF_FFFF. DIVU by 0 -> 32'hFFFF_FFFF at T+1. DIV 32'h8000_0000 by -1 -> 32'h8000_0000.
- Hold out_ready=0 for 5 cycles after XOR a=32'hF0F0_F0F0, b=32'hFFFF_FFFF -> result 32'h0F0F_0F0F stable and in_ready=0; on release, accept the next op in the same cycle.
- Assert rst at cycle 10 of a DIVU -> out_valid=0, busy=0, in_ready=1 immediately; a following ADD 2+3 returns 5 with no residue.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential execute-stage ALU: op codes, FSM states,
// status bit positions and op classification helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_XOR   = 4'd2,
    OP_OR    = 4'd3,
    OP_AND   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STAT_Z = 0;
  localparam int STAT_V = 1;
  localparam int STAT_N = 2;

  function automatic logic is_multicycle(input alu_op_t op);
    return (op >= OP_MUL);
  endfunction

  function automatic logic is_signed_div(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div_family(input alu_op_t op);
    return (op >= OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_mul_div_iter.sv
// Radix-2 iterative multiplier / restoring divider. One step per cycle for
// WIDTH cycles after start; done flags the final step and res is its outcome.
module mul_div_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(WIDTH);

  alu_op_t          op_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             neg_quo;
  logic             neg_rem;

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  // Magnitudes of the operands; only signed divide/remainder converts.
  always_comb begin
    sgn   = is_signed_div(op);
    a_mag = a;
    b_mag = b;
    if (sgn && a[WIDTH-1]) begin
      a_mag = {WIDTH{1'b0}} - a;
    end else begin
      a_mag = a;
    end
    if (sgn && b[WIDTH-1]) begin
      b_mag = {WIDTH{1'b0}} - b;
    end else begin
      b_mag = b;
    end
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on {hi, lo}.
  always_comb begin
    sum     = {(WIDTH+1){1'b0}};
    shifted = {hi, lo[WIDTH-1]};
    next_hi = hi;
    next_lo = lo;
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo[WIDTH-1:1]};
    end else if (shifted >= {1'b0, opnd}) begin
      next_hi = WIDTH'(shifted - {1'b0, opnd});
      next_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      next_hi = shifted[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection with sign restoration for signed divide.
  always_comb begin
    case (op_q)
      OP_MUL:           res = next_lo;
      OP_MULHU:         res = next_hi;
      OP_DIV, OP_DIVU:  res = neg_quo ? ({WIDTH{1'b0}} - next_lo) : next_lo;
      OP_REM, OP_REMU:  res = neg_rem ? ({WIDTH{1'b0}} - next_hi) : next_hi;
      default:          res = next_lo;
    endcase
  end

  assign done = active && (cnt == {CNT_W{1'b0}});

  // Iteration registers and down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_MUL;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      opnd    <= {WIDTH{1'b0}};
      cnt     <= {CNT_W{1'b0}};
      active  <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start) begin
      op_q    <= op;
      hi      <= {WIDTH{1'b0}};
      lo      <= a_mag;
      opnd    <= b_mag;
      cnt     <= CNT_W'(WIDTH - 1);
      active  <= 1'b1;
      neg_quo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem <= sgn && a[WIDTH-1];
    end else if (active) begin
      hi <= next_hi;
      lo <= next_lo;
      if (cnt == {CNT_W{1'b0}}) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle datapath, control FSM and the
// registered result/status; multiply/divide iterate in mul_div_iter.
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t             state;
  logic               accept;
  logic               start_iter;
  logic               bypass;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_v;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_res;

  function automatic logic [2:0] make_status(input logic [WIDTH-1:0] r, input logic v);
    logic [2:0] s;
    s         = 3'b000;
    s[STAT_N] = r[WIDTH-1];
    s[STAT_V] = v;
    s[STAT_Z] = (r == {WIDTH{1'b0}});
    return s;
  endfunction

  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid  = (state == DONE);
  assign busy       = (state == BUSY);
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_multicycle(op) && !bypass;

  // Divide corner cases resolve in one cycle instead of iterating.
  always_comb begin
    div_zero = (b == {WIDTH{1'b0}});
    div_ovf  = (a == MOST_NEG) && (b == ALL_ONES);
    if (is_div_family(op)) begin
      bypass = div_zero || (is_signed_div(op) && div_ovf);
    end else begin
      bypass = 1'b0;
    end
  end

  // Single-cycle datapath, including the divide bypass results.
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    shamt    = b[SHAMT_W-1:0];
    fast_res = {WIDTH{1'b0}};
    fast_v   = 1'b0;
    case (op)
      OP_ADD: begin
        fast_res = sum;
        fast_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = diff;
        fast_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  fast_res = a ^ b;
      OP_OR:   fast_res = a | b;
      OP_AND:  fast_res = a & b;
      OP_SLL:  fast_res = a << shamt;
      OP_SRL:  fast_res = a >> shamt;
      OP_SRA:  fast_res = $signed(a) >>> shamt;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_DIV:  fast_res = div_zero ? ALL_ONES : a;
      OP_DIVU: fast_res = ALL_ONES;
      OP_REM:  fast_res = div_zero ? a : {WIDTH{1'b0}};
      OP_REMU: fast_res = a;
      default: fast_res = {WIDTH{1'b0}};
    endcase
  end

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start_iter),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .res   (iter_res)
  );

  // Control FSM with the registered result and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= {WIDTH{1'b0}};
      status <= 3'b000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (start_iter) begin
              state <= BUSY;
            end else begin
              state  <= DONE;
              result <= fast_res;
              status <= make_status(fast_res, fast_v);
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end else begin
            state <= state;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state  <= DONE;
            result <= iter_res;
            status <= make_status(iter_res, 1'b0);
          end else begin
            state <= BUSY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
